mem_access: RTL and testbench

MEM_ACCESS -- requirements
Module: mem_access

---
 rtl/mem_access_pkg.sv | 54 +++++
 rtl/mem_load_ext.sv | 26 ++
 rtl/mem_access.sv | 201 ++++++++++++++++++++
 tb/tb_mem_access.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_pkg.sv
// Shared definitions for the memory-access stage: bus widths, the decoded
// instruction-type codes, stall constants, the stage FSM encoding and small
// helpers for transfer sizing and alignment.
package mem_access_pkg;

  localparam int REG_W       = 32;
  localparam int REG_ADDR_W  = 5;
  localparam int INST_TYPE_W = 5;

  typedef logic [REG_W-1:0]       reg_bus_t;
  typedef logic [REG_ADDR_W-1:0]  reg_addr_bus_t;
  typedef logic [INST_TYPE_W-1:0] inst_type_bus_t;

  localparam reg_bus_t ZERO_WORD = '0;
  localparam logic     STOP      = 1'b1;
  localparam logic     NOT_STOP  = 1'b0;

  // Decoded instruction types seen by this stage
  localparam inst_type_bus_t INST_NOP = 5'd0;
  localparam inst_type_bus_t INST_ADD = 5'd1;
  localparam inst_type_bus_t INST_LB  = 5'd2;
  localparam inst_type_bus_t INST_LH  = 5'd3;
  localparam inst_type_bus_t INST_LW  = 5'd4;
  localparam inst_type_bus_t INST_LBU = 5'd5;
  localparam inst_type_bus_t INST_LHU = 5'd6;
  localparam inst_type_bus_t INST_SB  = 5'd7;
  localparam inst_type_bus_t INST_SH  = 5'd8;
  localparam inst_type_bus_t INST_SW  = 5'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } mem_state_e;

  // Number of byte transfers an access needs; anything not byte/half is a word
  function automatic logic [2:0] access_bytes(input inst_type_bus_t t);
    case (t)
      INST_LB, INST_LBU, INST_SB: access_bytes = 3'd1;
      INST_LH, INST_LHU, INST_SH: access_bytes = 3'd2;
      default:                    access_bytes = 3'd4;
    endcase
  endfunction

  // Halfwords need an even address, words a 4-byte aligned one
  function automatic logic is_misaligned(input inst_type_bus_t t, input logic [1:0] a);
    case (t)
      INST_LH, INST_LHU, INST_SH: is_misaligned = a[0];
      INST_LW, INST_SW:           is_misaligned = (a != 2'b00);
      default:                    is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_ext.sv
// Assembles the little-endian load bytes into a register value and applies
// sign or zero extension according to the load type.
module mem_load_ext
  import mem_access_pkg::*;
(
  input  logic [7:0]     byte0_i,
  input  logic [7:0]     byte1_i,
  input  logic [7:0]     byte2_i,
  input  logic [7:0]     byte3_i,
  input  inst_type_bus_t inst_type_i,
  output reg_bus_t       load_val_o
);

  // Select width and extension from the load type
  always_comb begin
    load_val_o = ZERO_WORD;
    case (inst_type_i)
      INST_LB:  load_val_o = {{24{byte0_i[7]}}, byte0_i};
      INST_LBU: load_val_o = {24'd0, byte0_i};
      INST_LH:  load_val_o = {{16{byte1_i[7]}}, byte1_i, byte0_i};
      INST_LHU: load_val_o = {16'd0, byte1_i, byte0_i};
      default:  load_val_o = {byte3_i, byte2_i, byte1_i, byte0_i};
    endcase
  end

endmodule

// File: rtl/mem_access.sv
// Memory-access pipeline stage. Loads and stores are carried out one byte at
// a time over a request/ack handshake with the memory controller while the
// pipeline is stalled; other instructions pass straight through.
// Optional feature: define MEM_MISALIGN_CHECK_EN to reject misaligned
// halfword/word accesses instead of transferring them byte-serially.
module mem_access
  import mem_access_pkg::*;
(
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           rd_in,
  input  reg_bus_t       rd_val_in,
  input  reg_addr_bus_t  rd_addr_in,
  input  inst_type_bus_t inst_type_in,
  input  logic           load_in,
  input  logic           store_in,
  input  logic [31:0]    mem_addr_in,
  input  logic [31:0]    mem_val_in,
  input  logic [7:0]     mem_rdata_in,
  input  logic           mem_ack_in,
  output logic           rd_out,
  output reg_bus_t       rd_val_out,
  output reg_addr_bus_t  rd_addr_out,
  output logic           mem_req_out,
  output logic           mem_we_out,
  output logic [31:0]    mem_addr_out,
  output logic [7:0]     mem_wdata_out,
  output logic           stallreq_from_mem,
  output logic           misalign_out
);

  mem_state_e     state_q, state_d;
  logic [2:0]     cnt_q, cnt_d;
  logic [2:0]     nbytes_q, nbytes_d;
  logic [31:0]    base_q, base_d;
  logic [31:0]    wdata_q, wdata_d;
  inst_type_bus_t type_q, type_d;
  logic           rd_q, rd_d;
  reg_addr_bus_t  rd_addr_q, rd_addr_d;
  logic           store_q, store_d;
  logic [3:0][7:0] lane_q, lane_d;
  logic           misalign_q, misalign_d;

  logic           start;
  logic           misalign_now;
  reg_bus_t       load_val;

  // Exactly one of load/store starts an access; both high counts as none
  assign start = load_in ^ store_in;

`ifdef MEM_MISALIGN_CHECK_EN
  assign misalign_now = is_misaligned(inst_type_in, mem_addr_in[1:0]);
`else
  assign misalign_now = 1'b0;
`endif

  mem_load_ext u_load_ext (
    .byte0_i     (lane_q[0]),
    .byte1_i     (lane_q[1]),
    .byte2_i     (lane_q[2]),
    .byte3_i     (lane_q[3]),
    .inst_type_i (type_q),
    .load_val_o  (load_val)
  );

  // State register
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: IDLE -> ACCESS (or DONE when rejected) -> DONE on the last ack -> IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = misalign_now ? ST_DONE : ST_ACCESS;
        end
      end
      ST_ACCESS: begin
        if (mem_ack_in && ((cnt_q + 3'd1) == nbytes_q)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Transfer context: latched at start, byte lanes filled on each ack
  always_comb begin
    cnt_d      = cnt_q;
    nbytes_d   = nbytes_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    type_d     = type_q;
    rd_d       = rd_q;
    rd_addr_d  = rd_addr_q;
    store_d    = store_q;
    lane_d     = lane_q;
    misalign_d = misalign_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          cnt_d      = 3'd0;
          nbytes_d   = access_bytes(inst_type_in);
          base_d     = mem_addr_in;
          wdata_d    = mem_val_in;
          type_d     = inst_type_in;
          rd_d       = rd_in;
          rd_addr_d  = rd_addr_in;
          store_d    = store_in;
          lane_d     = '0;
          misalign_d = misalign_now;
        end
      end
      ST_ACCESS: begin
        if (mem_ack_in) begin
          lane_d[cnt_q[1:0]] = mem_rdata_in;
          cnt_d              = cnt_q + 3'd1;
        end
      end
      ST_DONE:  misalign_d = 1'b0;
      default: ;
    endcase
  end

  // Context registers
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      cnt_q      <= 3'd0;
      nbytes_q   <= 3'd0;
      base_q     <= 32'd0;
      wdata_q    <= 32'd0;
      type_q     <= INST_NOP;
      rd_q       <= 1'b0;
      rd_addr_q  <= '0;
      store_q    <= 1'b0;
      lane_q     <= '0;
      misalign_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      nbytes_q   <= nbytes_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      type_q     <= type_d;
      rd_q       <= rd_d;
      rd_addr_q  <= rd_addr_d;
      store_q    <= store_d;
      lane_q     <= lane_d;
      misalign_q <= misalign_d;
    end
  end

  // Outputs; reset forces everything low so an aborted transfer drops its request at once
  always_comb begin
    rd_out            = 1'b0;
    rd_val_out        = ZERO_WORD;
    rd_addr_out       = '0;
    mem_req_out       = 1'b0;
    mem_we_out        = 1'b0;
    mem_addr_out      = 32'd0;
    mem_wdata_out     = 8'd0;
    stallreq_from_mem = NOT_STOP;
    misalign_out      = 1'b0;
    if (rst_in) begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            stallreq_from_mem = STOP;
          end else begin
            rd_out      = rd_in;
            rd_val_out  = rd_val_in;
            rd_addr_out = rd_addr_in;
          end
        end
        ST_ACCESS: begin
          mem_req_out       = 1'b1;
          mem_we_out        = store_q;
          mem_addr_out      = base_q + {29'd0, cnt_q};
          mem_wdata_out     = wdata_q[{cnt_q[1:0], 3'b000} +: 8];
          stallreq_from_mem = STOP;
        end
        ST_DONE: begin
          rd_out      = rd_q & ~store_q & ~misalign_q;
          rd_val_out  = (store_q | misalign_q) ? ZERO_WORD : load_val;
          rd_addr_out = rd_addr_q;
`ifdef MEM_MISALIGN_CHECK_EN
          misalign_out = misalign_q;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// Directed bench for mem_access: a byte-serial memory responder acks every
// second request cycle; expected addresses, store bytes and load results are
// queued when each access is issued and compared as the DUT produces them.
module tb_mem_access;
  import mem_access_pkg::*;

  logic           clk_in = 1'b0;
  logic           rst_in;
  logic           rd_in;
  reg_bus_t       rd_val_in;
  reg_addr_bus_t  rd_addr_in;
  inst_type_bus_t inst_type_in;
  logic           load_in;
  logic           store_in;
  logic [31:0]    mem_addr_in;
  logic [31:0]    mem_val_in;
  logic [7:0]     mem_rdata_in;
  logic           mem_ack_in;
  logic           rd_out;
  reg_bus_t       rd_val_out;
  reg_addr_bus_t  rd_addr_out;
  logic           mem_req_out;
  logic           mem_we_out;
  logic [31:0]    mem_addr_out;
  logic [7:0]     mem_wdata_out;
  logic           stallreq_from_mem;
  logic           misalign_out;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] exp_addr_q[$];
  logic [7:0]  exp_wdata_q[$];
  logic [7:0]  rsp_q[$];
  logic [31:0] exp_wb_q[$];

  always #5 clk_in = ~clk_in;

  mem_access dut (
    .clk_in            (clk_in),
    .rst_in            (rst_in),
    .rd_in             (rd_in),
    .rd_val_in         (rd_val_in),
    .rd_addr_in        (rd_addr_in),
    .inst_type_in      (inst_type_in),
    .load_in           (load_in),
    .store_in          (store_in),
    .mem_addr_in       (mem_addr_in),
    .mem_val_in        (mem_val_in),
    .mem_rdata_in      (mem_rdata_in),
    .mem_ack_in        (mem_ack_in),
    .rd_out            (rd_out),
    .rd_val_out        (rd_val_out),
    .rd_addr_out       (rd_addr_out),
    .mem_req_out       (mem_req_out),
    .mem_we_out        (mem_we_out),
    .mem_addr_out      (mem_addr_out),
    .mem_wdata_out     (mem_wdata_out),
    .stallreq_from_mem (stallreq_from_mem),
    .misalign_out      (misalign_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  // Issue one load/store, serve its bytes, then check DONE and the return to IDLE
  task automatic run_access(input string name, input inst_type_bus_t t, input logic is_st,
                            input logic [31:0] addr, input logic [31:0] wval,
                            input logic [31:0] rword, input int nb, input logic [31:0] exp_wb);
    int stall_cyc;
    int wait_c;
    int seen;
    logic [31:0] ea;
    logic [7:0]  ew;
    for (int i = 0; i < nb; i++) begin
      exp_addr_q.push_back(addr + 32'(i));
      exp_wdata_q.push_back(wval[8*i +: 8]);
      rsp_q.push_back(rword[8*i +: 8]);
    end
    if (!is_st) exp_wb_q.push_back(exp_wb);
    inst_type_in = t;
    load_in      = !is_st;
    store_in     = is_st;
    mem_addr_in  = addr;
    mem_val_in   = wval;
    rd_in        = !is_st;
    rd_addr_in   = 5'd7;
    rd_val_in    = 32'hDEAD0000;
    #1;
    check({name, " start_stall"}, 32'(stallreq_from_mem), 32'd1);
    check({name, " start_req"}, 32'(mem_req_out), 32'd0);
    step();
    // Upstream changes while busy must not disturb the latched access
    load_in      = 1'b0;
    store_in     = 1'b0;
    inst_type_in = INST_ADD;
    mem_addr_in  = 32'h0;
    mem_val_in   = 32'h0;
    rd_in        = 1'b1;
    rd_addr_in   = 5'd30;
    rd_val_in    = 32'h0BAD0BAD;
    stall_cyc = 0;
    wait_c    = 0;
    seen      = 0;
    for (int cyc = 0; cyc < 64; cyc++) begin
      if (!mem_req_out) break;
      if (stallreq_from_mem) stall_cyc++;
      wait_c++;
      if (wait_c == 2) begin
        wait_c = 0;
        if (exp_addr_q.size() == 0) begin
          check({name, " byte_count"}, 32'(seen + 1), 32'(nb));
          break;
        end
        seen++;
        ea = exp_addr_q.pop_front();
        ew = exp_wdata_q.pop_front();
        check({name, " addr"}, mem_addr_out, ea);
        check({name, " we"}, 32'(mem_we_out), 32'(is_st));
        if (is_st) check({name, " wdata"}, 32'(mem_wdata_out), 32'(ew));
        mem_rdata_in = rsp_q.pop_front();
        mem_ack_in   = 1'b1;
      end
      step();
      mem_ack_in   = 1'b0;
      mem_rdata_in = 8'h00;
    end
    check({name, " req_dropped"}, 32'(mem_req_out), 32'd0);
    check({name, " stall_cycles"}, 32'(stall_cyc), 32'(2 * nb));
    check({name, " bytes_left"}, 32'(exp_addr_q.size()), 32'd0);
    check({name, " done_stall"}, 32'(stallreq_from_mem), 32'd0);
    check({name, " done_rd"}, 32'(rd_out), 32'(!is_st));
    check({name, " done_rd_addr"}, 32'(rd_addr_out), 32'd7);
    check({name, " done_misalign"}, 32'(misalign_out), 32'd0);
    if (!is_st) check({name, " done_val"}, rd_val_out, exp_wb_q.pop_front());
    exp_addr_q.delete();
    exp_wdata_q.delete();
    rsp_q.delete();
    step();
    check({name, " idle_pass_val"}, rd_val_out, 32'h0BAD0BAD);
    check({name, " idle_pass_addr"}, 32'(rd_addr_out), 32'd30);
    check({name, " idle_stall"}, 32'(stallreq_from_mem), 32'd0);
    $display("txn %s addr=0x%08h bytes=%0d", name, addr, nb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset with busy-looking inputs: every output must stay low
    rst_in       = 1'b0;
    rd_in        = 1'b1;
    rd_val_in    = 32'h12345678;
    rd_addr_in   = 5'd5;
    inst_type_in = INST_LW;
    load_in      = 1'b1;
    store_in     = 1'b0;
    mem_addr_in  = 32'h100;
    mem_val_in   = 32'h0;
    mem_rdata_in = 8'h00;
    mem_ack_in   = 1'b1;
    #2;
    check("reset rd_out", 32'(rd_out), 32'd0);
    check("reset rd_val", rd_val_out, 32'd0);
    check("reset req", 32'(mem_req_out), 32'd0);
    check("reset stall", 32'(stallreq_from_mem), 32'd0);
    step();
    step();
    load_in    = 1'b0;
    mem_ack_in = 1'b0;
    rst_in     = 1'b1;
    $display("txn reset released");

    // ADD pass-through
    inst_type_in = INST_ADD;
    rd_in        = 1'b1;
    rd_addr_in   = 5'd5;
    rd_val_in    = 32'h12345678;
    #1;
    check("add rd_val", rd_val_out, 32'h12345678);
    check("add rd_out", 32'(rd_out), 32'd1);
    check("add rd_addr", 32'(rd_addr_out), 32'd5);
    check("add stall", 32'(stallreq_from_mem), 32'd0);
    check("add req", 32'(mem_req_out), 32'd0);
    $display("txn add pass-through");

    // load and store both high, plus a stray ack: no access is started
    step();
    inst_type_in = INST_LW;
    load_in      = 1'b1;
    store_in     = 1'b1;
    mem_ack_in   = 1'b1;
    rd_val_in    = 32'h0F0F0F0F;
    #1;
    check("both rd_val", rd_val_out, 32'h0F0F0F0F);
    check("both stall", 32'(stallreq_from_mem), 32'd0);
    step();
    check("both req_after", 32'(mem_req_out), 32'd0);
    check("both stall_after", 32'(stallreq_from_mem), 32'd0);
    load_in    = 1'b0;
    store_in   = 1'b0;
    mem_ack_in = 1'b0;
    $display("txn load+store ignored");

    run_access("lw", INST_LW, 1'b0, 32'h100, 32'h0, 32'h12345678, 4, 32'h12345678);
    run_access("lb", INST_LB, 1'b0, 32'h200, 32'h0, 32'h00000080, 1, 32'hFFFFFF80);
    run_access("lbu", INST_LBU, 1'b0, 32'h200, 32'h0, 32'h00000080, 1, 32'h00000080);
    run_access("lh", INST_LH, 1'b0, 32'h400, 32'h0, 32'h00008001, 2, 32'hFFFF8001);
    run_access("lhu", INST_LHU, 1'b0, 32'h400, 32'h0, 32'h00008001, 2, 32'h00008001);
    run_access("sh", INST_SH, 1'b1, 32'h300, 32'hAABBCCDD, 32'h0, 2, 32'h0);
    run_access("sw", INST_SW, 1'b1, 32'h500, 32'h01020304, 32'h0, 4, 32'h0);

    // Reset after the first ack of a word load aborts it
    inst_type_in = INST_LW;
    load_in      = 1'b1;
    mem_addr_in  = 32'h100;
    rd_in        = 1'b1;
    rd_addr_in   = 5'd3;
    step();
    load_in = 1'b0;
    rd_in   = 1'b0;
    step();
    mem_rdata_in = 8'h78;
    mem_ack_in   = 1'b1;
    step();
    mem_ack_in = 1'b0;
    check("abort req_before", 32'(mem_req_out), 32'd1);
    rst_in = 1'b0;
    #1;
    check("abort req", 32'(mem_req_out), 32'd0);
    check("abort stall", 32'(stallreq_from_mem), 32'd0);
    check("abort rd_out", 32'(rd_out), 32'd0);
    step();
    rst_in = 1'b1;
    #1;
    check("abort idle_req", 32'(mem_req_out), 32'd0);
    check("abort idle_stall", 32'(stallreq_from_mem), 32'd0);
    step();
    check("abort no_wb", 32'(rd_out), 32'd0);
    check("abort still_idle", 32'(mem_req_out), 32'd0);
    rd_in     = 1'b1;
    rd_val_in = 32'h55AA55AA;
    #1;
    check("abort pass_val", rd_val_out, 32'h55AA55AA);
    check("abort pass_stall", 32'(stallreq_from_mem), 32'd0);
    $display("txn reset mid-access");
    step();

`ifdef MEM_MISALIGN_CHECK_EN
    // Misaligned word load is rejected without touching memory
    inst_type_in = INST_LW;
    load_in      = 1'b1;
    mem_addr_in  = 32'h102;
    rd_in        = 1'b1;
    rd_addr_in   = 5'd9;
    #1;
    check("mis start_stall", 32'(stallreq_from_mem), 32'd1);
    check("mis start_req", 32'(mem_req_out), 32'd0);
    step();
    load_in = 1'b0;
    rd_in   = 1'b0;
    #1;
    check("mis req", 32'(mem_req_out), 32'd0);
    check("mis flag", 32'(misalign_out), 32'd1);
    check("mis rd_out", 32'(rd_out), 32'd0);
    check("mis stall", 32'(stallreq_from_mem), 32'd0);
    step();
    check("mis flag_end", 32'(misalign_out), 32'd0);
    check("mis req_end", 32'(mem_req_out), 32'd0);
    $display("txn misaligned lw rejected");
`else
    // Misaligned accesses proceed byte by byte; addresses wrap at 2^32
    run_access("lw_mis", INST_LW, 1'b0, 32'h102, 32'h0, 32'h44332211, 4, 32'h44332211);
    run_access("lw_wrap", INST_LW, 1'b0, 32'hFFFFFFFE, 32'h0, 32'hA1B2C3D4, 4, 32'hA1B2C3D4);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
